// File: rtl/switch_mcu_ahb_pkg.sv
// AHB-Lite encodings and IFU state type shared by the instruction-fetch slice.
package switch_mcu_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_OPCODE  = 4'b0010;

   typedef enum logic [1:0] {
      IFU_IDLE  = 2'b00,
      IFU_FETCH = 2'b01,
      IFU_HALT  = 2'b10
   } ifu_state_t;

endpackage

// File: rtl/switch_mcu_sync_fifo.sv
// Synchronous FIFO with flush; pop data is zero when empty; 1-cycle push-to-visible latency.
// Push is refused when full unless a pop happens on the same edge; flush wins over push/pop.
module switch_mcu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] pop_dat,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign pop_dat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/switch_mcu_ifu_pf.sv
// AHB-Lite instruction fetch with prefetch FIFO; address cycle N -> inst valid in N+2.
// Issues only while FIFO entries plus in-flight transfers leave a free slot; decoder stall throttles the bus.
module switch_mcu_ifu_pf
   import switch_mcu_ahb_pkg::*;
#(
   parameter int              ADDR_W     = 32,
   parameter int              DATA_W     = 32,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_init_done,
   input  logic              in_redirect,
   input  logic [ADDR_W-1:0] in_redirect_pc,
   input  logic              in_inst_ready,
   output logic              out_inst_valid,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_inst_pc,
   output logic              out_inst_err,
   input  logic              in_hready,
   input  logic              in_hresp,
   input  logic [DATA_W-1:0] in_hrdata,
   output logic [ADDR_W-1:0] out_haddr,
   output logic              out_hwrite,
   output logic [2:0]        out_hsize,
   output logic [2:0]        out_hburst,
   output logic [3:0]        out_hport,
   output logic [1:0]        out_htrans,
   output logic              out_hmastlock
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
      logic              err;
   } ent_t;

   ifu_state_t        state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] ap_addr;
   logic              ap_hold;
   logic              ap_stale;
   logic              dph_vld;
   logic [ADDR_W-1:0] dph_pc;
   logic              dph_stale;

   logic [ADDR_W-1:0] addr_cur;
   logic [ADDR_W-1:0] redirect_pc_w;
   logic              stale_cur;
   logic              err_phase;
   logic              issue_new;
   logic              drive;
   logic              dph_done;
   logic              err_done;
   logic              push;
   logic              pop;
   logic              credit_ok;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    inflight;
   logic              fifo_full;
   logic              fifo_empty;
   ent_t              push_ent;
   ent_t              head_ent;

   assign out_hwrite    = 1'b0;
   assign out_hsize     = HSIZE_WORD;
   assign out_hburst    = HBURST_SINGLE;
   assign out_hport     = HPROT_OPCODE;
   assign out_hmastlock = 1'b0;

   assign redirect_pc_w = in_redirect_pc & ~ADDR_W'(3);
   assign inflight      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, dph_vld};
   assign credit_ok     = ~fifo_full & (inflight < (CNT_W+1)'(FIFO_DEPTH));

   // A stalled address phase keeps its own address so a redirect cannot disturb it.
   assign addr_cur  = ap_hold ? ap_addr : fetch_pc;
   assign stale_cur = ap_hold & ap_stale;
   assign err_phase = dph_vld & in_hresp;
   assign issue_new = (state == IFU_FETCH) & in_init_done & credit_ok & ~in_redirect;
   assign drive     = (ap_hold | issue_new) & ~err_phase;

   assign out_htrans = drive ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign out_haddr  = addr_cur;

   assign dph_done = dph_vld & in_hready;
   assign err_done = dph_done & in_hresp & ~dph_stale;
   assign push     = dph_done & ~dph_stale & ~in_redirect;
   assign pop      = out_inst_valid & in_inst_ready & ~in_redirect;

   assign push_ent.pc   = dph_pc;
   assign push_ent.inst = in_hresp ? '0 : in_hrdata;
   assign push_ent.err  = in_hresp;

   always_comb begin
      state_nxt = state;
      case (state)
         IFU_IDLE:  if (in_init_done) state_nxt = IFU_FETCH;
         IFU_FETCH: begin
            if (in_redirect)                               state_nxt = IFU_FETCH;
            else if (err_done)                             state_nxt = IFU_HALT;
            else if (!in_init_done && !ap_hold && !dph_vld) state_nxt = IFU_IDLE;
         end
         IFU_HALT:  if (in_redirect) state_nxt = IFU_FETCH;
         default:   state_nxt = IFU_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state     <= IFU_IDLE;
         fetch_pc  <= RESET_PC;
         ap_hold   <= 1'b0;
         ap_addr   <= '0;
         ap_stale  <= 1'b0;
         dph_vld   <= 1'b0;
         dph_pc    <= '0;
         dph_stale <= 1'b0;
      end else begin
         state <= state_nxt;

         if (in_redirect)
            fetch_pc <= redirect_pc_w;
         else if (drive && in_hready && !stale_cur)
            fetch_pc <= addr_cur + ADDR_W'(4);

         ap_hold <= drive & ~in_hready;
         if (drive && !in_hready) begin
            ap_addr  <= addr_cur;
            ap_stale <= stale_cur | in_redirect;
         end

         // Stale transfers still occupy a credit until their data phase retires.
         if (in_hready) begin
            dph_vld   <= drive;
            dph_pc    <= addr_cur;
            dph_stale <= stale_cur | in_redirect;
         end else if (in_redirect) begin
            dph_stale <= 1'b1;
         end
      end
   end

   switch_mcu_sync_fifo #(
      .WIDTH ($bits(ent_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (in_clk),
      .rst_n    (in_rst),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .flush    (in_redirect),
      .pop_dat  (head_ent),
      .count    (fifo_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign out_inst_valid = ~fifo_empty;
   assign out_inst       = head_ent.inst;
   assign out_inst_pc    = head_ent.pc;
   assign out_inst_err   = head_ent.err;

endmodule
